// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and slice width.
package multicycle_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : multicycle_adder_pkg

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder slice, reused one slice at a time by multicycle_adder.
module rca_4bit
  import multicycle_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W-1:0] s;
  logic               c;

  // Bit-serial ripple through the four full adders.
  always_comb begin
    c = cin_i;
    s = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a_i[i] ^ b_i[i] ^ c;
      c    = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end

  assign sum_o  = s;
  assign cout_o = c;

endmodule : rca_4bit

// File: rtl/multicycle_adder.sv
// Wide adder that reuses one rca_4bit over WIDTH/4 cycles with a registered inter-slice carry.
// Optional signed-overflow flag is enabled by defining MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("multicycle_adder: WIDTH must be a positive multiple of 4");
  end

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  rca_4bit u_rca (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

`ifdef MULTICYCLE_ADDER_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Handshake FSM plus slice datapath; rst overrides every handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in1;
            b_q        <= in2;
            carry_q    <= cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ADD: begin
          sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_cout;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
`ifdef MULTICYCLE_ADDER_OVF_EN
            // Final slice's bit 3 is the result MSB; compare against latched operand signs.
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : multicycle_adder

// File: tb/tb_multicycle_adder.sv
// Directed, table-driven bench for multicycle_adder (WIDTH=16); ovf expectations follow MULTICYCLE_ADDER_OVF_EN.
module tb_multicycle_adder;

  localparam int W = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad = 0;

  multicycle_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic v);
`ifdef MULTICYCLE_ADDER_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Waits (bounded) for in_ready, then presents one operand set for exactly one edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in1 = a;
    in2 = b;
    cin = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].c);
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      wait_valid(lat);
      chk("latency", 64'(lat), 64'(NSLICE));
      chk("sum", 64'(sum), 64'(vecs[i].s));
      chk("cout", 64'(cout), 64'(vecs[i].co));
      chk("ovf", 64'(ovf), 64'(exp_ovf(vecs[i].ov)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("drain_out_valid", 64'(out_valid), 64'd0);
      chk("drain_in_ready", 64'(in_ready), 64'd1);
      chk("retain_sum", 64'(sum), 64'(vecs[i].s));
    end

    // Busy: new operands pulsed during ADD must not disturb the accepted operation.
    accept(16'h1234, 16'h4321, 1'b0);
    in1 = 16'hFFFF;
    in2 = 16'hFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    in1 = 16'h0F0F;
    wait_valid(lat);
    chk("busy_latency", 64'(lat), 64'(NSLICE - 1));
    chk("busy_sum", 64'(sum), 64'h5555);
    chk("busy_cout", 64'(cout), 64'd0);

    // Back-pressure: five cycles in DONE with out_ready low, in_valid poking too.
    held_sum = sum;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", 64'(sum), 64'(held_sum));
      chk("bp_cout", 64'(cout), 64'd0);
      chk("bp_ovf", 64'(ovf), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", 64'(out_valid), 64'd0);

    // Reset on the second ADD cycle, with out_ready and in_valid also high on that edge.
    accept(16'hFFFF, 16'h0001, 1'b0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midrst_stays_idle", 64'(out_valid), 64'd0);
    end
    accept(16'h0005, 16'h0006, 1'b0);
    wait_valid(lat);
    chk("post_rst_latency", 64'(lat), 64'(NSLICE));
    chk("post_rst_sum", 64'(sum), 64'h000B);
    chk("post_rst_cout", 64'(cout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multicycle_adder
